// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and helpers for the load/store unit
// Contents:
//   funct3 codes (F3_*), RAM format codes (FMT_*), FSM state type (state_t),
//   LFSR seed/taps for the optional random ACCESS stretch (LSU_RAND_DELAY_EN),
//   req_illegal(): request legality check, lfsr_next(): one LFSR step.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FMT_BYTE = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Unsigned variants exist only for loads; half/word need natural alignment.
  function automatic logic req_illegal(input logic       store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - EXU request, RAM data port and WBU response bundle of the load/store unit
// Modports:
//   slave  : the LSU side (consumes requests and RAM read data, drives RAM and responses)
//   master : the environment side (EXU + RAM + WBU)
// Signals: req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata,
//          mem_we/mem_format/mem_addr/mem_wdata/mem_rdata,
//          resp_valid/resp_ready/resp_rdata/resp_err
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  mem_we;
  logic [1:0]            mem_format;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_rdata, resp_ready,
    output req_ready, mem_we, mem_format, mem_addr, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_rdata, resp_ready,
    input  req_ready, mem_we, mem_format, mem_addr, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - funct3-driven sign/zero extension of RAM load data
// Ports:
//   i_funct3 : load funct3 (B/H/W/BU/HU)
//   i_rdata  : RAM read data, addressed bytes in the low lanes
//   o_data   : extended load result
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){i_rdata[7]}}, i_rdata[7:0]};
      F3_H:    o_data = {{(DATA_WIDTH-16){i_rdata[15]}}, i_rdata[15:0]};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, i_rdata[7:0]};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, i_rdata[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between EXU/WBU and the data side of the unified RAM
// Optional feature macro: LSU_RAND_DELAY_EN (LFSR-driven 1..4 cycle ACCESS stretch).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_if.slave - request, RAM data port and response signals
// Flow: IDLE accepts one request, ACCESS drives the RAM, RESP holds the result
// until WBU takes it. Illegal requests skip ACCESS and never write.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_illegal = req_illegal(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

`ifdef LSU_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic [1:0] r_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
      r_wait <= 2'd0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_accept && !w_illegal) begin
        r_wait <= r_lfsr[1:0];
      end else if ((r_state == S_ACCESS) && (r_wait != 2'd0)) begin
        r_wait <= r_wait - 2'd1;
      end
    end
  end

  // RAM write and load sampling happen only once the wait count has drained
  assign w_last = (r_wait == 2'd0);
`else
  assign w_last = 1'b1;
`endif

  lsu_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .i_funct3(r_funct3),
    .i_rdata (bus.mem_rdata),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_RESP;
      S_RESP:   if (bus.resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // mem_we decodes only registered state, so it cannot glitch on request inputs
  // and it falls with the asynchronous reset of r_state.
  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.mem_we     = (r_state == S_ACCESS) && r_store && w_last;
    bus.mem_format = r_funct3[1:0];
    bus.mem_addr   = r_addr;
    bus.mem_wdata  = r_wdata;
    bus.resp_valid = (r_state == S_RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= bus.req_store;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_err    <= w_illegal;
        // stores and errors report zero data
        r_rdata  <= '0;
      end else if ((r_state == S_ACCESS) && w_last && !r_store) begin
        r_rdata  <= w_ext;
      end
    end
  end

endmodule
